// File: rtl/cr_ahbl_pkg.sv
// cr_ahbl_pkg: shared FSM encoding and AHB-Lite constants for the fair arbiter
package cr_ahbl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_ERR = 2'd2} state_t;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
endpackage

// File: rtl/cr_ahbl_starve_cnt.sv
// cr_ahbl_starve_cnt: counts dbus grants taken while ibus waits, saturating at LIMIT
// Ports: clk/rst (async active-high), ibus_req, ibus_grnt, dbus_grnt in; hit out (count == LIMIT).
module cr_ahbl_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ibus_req,
  input  logic ibus_grnt,
  input  logic dbus_grnt,
  output logic hit
);
  localparam logic [3:0] LIM = 4'(LIMIT);
  logic [3:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (ibus_grnt) cnt <= '0;
    else if (dbus_grnt && ibus_req && cnt != LIM) cnt <= cnt + 4'd1;
  assign hit = cnt == LIM;
endmodule

// File: rtl/cr_ahbl_fair_arb.sv
// cr_ahbl_fair_arb: two-requester AHB-Lite master arbiter, one transfer outstanding
// Ports: forever_cpuclk/cpurst (async active-high); ibus_*/dbus_* requester side with
// grnt/data_vld/acc_err/trans_cmplt pulses and shared arb_rdata; h* AHB-Lite master bus;
// arb_idle high when idle with no request.
// Macro CR_AHBL_ARB_STARVE_EN: ibus gets the bus after STARVE_LIMIT dbus grants while
// it waits; without it dbus has strict priority and STARVE_LIMIT is unused.
module cr_ahbl_fair_arb
  import cr_ahbl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        ibus_req,
  input  logic [31:0] ibus_addr,
  input  logic [1:0]  ibus_size,
  input  logic [3:0]  ibus_prot,
  input  logic        dbus_req,
  input  logic [31:0] dbus_addr,
  input  logic [1:0]  dbus_size,
  input  logic [3:0]  dbus_prot,
  input  logic        dbus_write,
  input  logic [31:0] dbus_wdata,
  output logic        ibus_grnt,
  output logic        dbus_grnt,
  output logic        ibus_data_vld,
  output logic        dbus_data_vld,
  output logic        ibus_acc_err,
  output logic        dbus_acc_err,
  output logic        ibus_trans_cmplt,
  output logic        dbus_trans_cmplt,
  output logic [31:0] arb_rdata,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        arb_idle
);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be 1..15");
  end
  state_t      state, state_nxt;
  logic        owner_i;
  logic [31:0] wdata_q;
  logic        starve_hit, sel_i, addr_ph, grant, done_ok, done_err;
`ifdef CR_AHBL_ARB_STARVE_EN
  cr_ahbl_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (forever_cpuclk),
    .rst       (cpurst),
    .ibus_req  (ibus_req),
    .ibus_grnt (ibus_grnt),
    .dbus_grnt (dbus_grnt),
    .hit       (starve_hit)
  );
`else
  assign starve_hit = 1'b0;
`endif
  assign sel_i   = ibus_req & (~dbus_req | starve_hit);
  // Gated by cpurst so no grant or address phase leaks out while reset is held.
  assign addr_ph = state == ST_IDLE && (ibus_req || dbus_req) && !cpurst;
  assign grant   = addr_ph & hready;
  always_ff @(posedge forever_cpuclk or posedge cpurst)
    if (cpurst) begin
      state   <= ST_IDLE;
      owner_i <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner_i <= sel_i;
        wdata_q <= dbus_wdata;
      end
    end
  // An error seen with hready already high completes at once rather than stalling in ERR.
  always_comb begin
    done_ok   = !cpurst && state == ST_DATA && hready && !hresp;
    done_err  = !cpurst && hready && (state == ST_ERR || (state == ST_DATA && hresp));
    state_nxt = grant ? ST_DATA :
                (done_ok || done_err) ? ST_IDLE :
                (state == ST_DATA && hresp) ? ST_ERR : state;
  end
  assign ibus_grnt        = grant & sel_i;
  assign dbus_grnt        = grant & ~sel_i;
  assign ibus_data_vld    = done_ok & owner_i;
  assign dbus_data_vld    = done_ok & ~owner_i;
  assign ibus_acc_err     = done_err & owner_i;
  assign dbus_acc_err     = done_err & ~owner_i;
  assign ibus_trans_cmplt = (done_ok | done_err) & owner_i;
  assign dbus_trans_cmplt = (done_ok | done_err) & ~owner_i;
  assign arb_rdata        = done_ok ? hrdata : '0;
  assign htrans           = addr_ph ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr            = addr_ph ? (sel_i ? ibus_addr : dbus_addr) : '0;
  assign hwrite           = addr_ph & ~sel_i & dbus_write;
  assign hsize            = addr_ph ? {1'b0, sel_i ? ibus_size : dbus_size} : '0;
  assign hprot            = addr_ph ? (sel_i ? ibus_prot : dbus_prot) : '0;
  assign hburst           = HBURST_SINGLE;
  assign hwdata           = state != ST_IDLE ? wdata_q : '0;
  assign arb_idle         = state == ST_IDLE && !ibus_req && !dbus_req;
endmodule
